// File: rtl/float_classify_stream.sv
// float_classify_stream: streaming IEEE-754 classifier with per-class saturating counters and sticky flags
module float_classify_stream #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4:0]             out_type,
    output logic                   out_sign,
    output logic                   out_snan,
    input  logic                   cnt_clr,
    input  logic [2:0]             cnt_sel,
    output logic [CNT_W-1:0]       cnt_rdata,
    output logic [4:0]             sticky
);
    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
    logic             exp_zero, exp_ones, man_zero, accept;
    logic [4:0]       cls;
    logic [CNT_W-1:0] cnt [5];

    assign exp_f    = in_data[EXP_W+MAN_W-1:MAN_W];
    assign man_f    = in_data[MAN_W-1:0];
    assign exp_zero = ~|exp_f;
    assign exp_ones = &exp_f;
    assign man_zero = ~|man_f;
    assign cls      = {exp_ones & ~man_zero, exp_ones & man_zero, exp_zero & ~man_zero,
                       ~exp_zero & ~exp_ones, exp_zero & man_zero};
    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_type  <= '0;
            out_sign  <= 1'b0;
            out_snan  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_type  <= cls;
            out_sign  <= in_data[EXP_W+MAN_W];
            out_snan  <= cls[4] & ~man_f[MAN_W-1];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // clear takes priority over a same-cycle accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 5; k++) cnt[k] <= '0;
            sticky <= '0;
        end else begin
            for (int k = 0; k < 5; k++)
                if (cnt_clr) cnt[k] <= '0;
                else if (accept && cls[k] && !(&cnt[k])) cnt[k] <= cnt[k] + CNT_W'(1);
            sticky <= cnt_clr ? '0 : sticky | ({5{accept}} & cls);
        end
    end

    always_comb begin
        cnt_rdata = '0;
        for (int k = 0; k < 5; k++)
            if (cnt_sel == 3'(k)) cnt_rdata = cnt[k];
    end
endmodule

// File: tb/tb_float_classify_stream.sv
// tb_float_classify_stream: scoreboard bench for single, half precision and narrow-counter instances
module tb_float_classify_stream;
    typedef struct {
        logic [4:0] t;
        logic       s;
        logic       sn;
        int         due;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        v0 = 0, r0 = 1, clr0 = 0, v1 = 0, clr1 = 0, v2 = 0;
    logic [31:0] d0 = 0, d1 = 0;
    logic [15:0] d2 = 0;
    logic [2:0]  sel0 = 0, sel1 = 1;
    logic        ir0, ov0, os0, sn0, ir1, ov1, os1, sn1, ir2, ov2, os2, sn2;
    logic [4:0]  ot0, ot1, ot2, st0, st1, st2;
    logic [15:0] cr0, cr2;
    logic [3:0]  cr1;
    int          checks = 0, errors = 0, cyc = 0;
    exp_t        q0[$], q2[$];
    exp_t        m0, m2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    float_classify_stream u_sp (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(ir0), .in_data(d0),
        .out_valid(ov0), .out_ready(r0), .out_type(ot0), .out_sign(os0), .out_snan(sn0),
        .cnt_clr(clr0), .cnt_sel(sel0), .cnt_rdata(cr0), .sticky(st0));

    float_classify_stream #(.CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(ir1), .in_data(d1),
        .out_valid(ov1), .out_ready(1'b1), .out_type(ot1), .out_sign(os1), .out_snan(sn1),
        .cnt_clr(clr1), .cnt_sel(sel1), .cnt_rdata(cr1), .sticky(st1));

    float_classify_stream #(.EXP_W(5), .MAN_W(10)) u_hp (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(ir2), .in_data(d2),
        .out_valid(ov2), .out_ready(1'b1), .out_type(ot2), .out_sign(os2), .out_snan(sn2),
        .cnt_clr(1'b0), .cnt_sel(3'd0), .cnt_rdata(cr2), .sticky(st2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send0(input logic [31:0] d, input logic [4:0] t, input logic sn, input bit exact);
        exp_t e;
        e.t = t; e.s = d[31]; e.sn = sn; e.due = exact ? cyc + 1 : -1;
        v0 = 1; d0 = d;
        q0.push_back(e);
        step();
        v0 = 0;
        if (exact) chk("sp_out_valid_after_accept", ov0, 1);
    endtask

    always @(negedge clk) if (rst_n && ov0 && r0) begin
        if (q0.size() == 0) chk("sp_unexpected_output", 1, 0);
        else begin
            m0 = q0.pop_front();
            chk("sp_type", ot0, m0.t);
            chk("sp_sign", os0, m0.s);
            chk("sp_snan", sn0, m0.sn);
            if (m0.due >= 0) chk("sp_latency", cyc, m0.due);
        end
    end

    always @(negedge clk) if (rst_n && ov2) begin
        if (q2.size() == 0) chk("hp_unexpected_output", 1, 0);
        else begin
            m2 = q2.pop_front();
            chk("hp_type", ot2, m2.t);
            chk("hp_sign", os2, m2.s);
            chk("hp_snan", sn2, m2.sn);
            chk("hp_latency", cyc, m2.due);
        end
    end

    logic [31:0] sp_d [12] = '{32'h00000000, 32'h3F800000, 32'h00000001, 32'h7F800000, 32'h7FC00000, 32'h7F800001,
                               32'h80000000, 32'hBF800000, 32'h80000001, 32'hFF800000, 32'hFFC00000, 32'hFF800001};
    logic [4:0]  sp_t [12] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b10000,
                               5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b10000};
    logic        sp_sn [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    logic [15:0] hp_d [6] = '{16'h7C00, 16'h0400, 16'h03FF, 16'h7E00, 16'h8000, 16'h7C01};
    logic [4:0]  hp_t [6] = '{5'b01000, 5'b00010, 5'b00100, 5'b10000, 5'b00001, 5'b10000};
    logic        hp_s [6] = '{0, 0, 0, 0, 1, 0};
    logic        hp_sn [6] = '{0, 0, 0, 0, 0, 1};

    initial begin
        exp_t e;
        #12;
        chk("rst_out_valid", ov0, 0);
        chk("rst_out_type", ot0, 0);
        chk("rst_out_sign", os0, 0);
        chk("rst_out_snan", sn0, 0);
        chk("rst_sticky", st0, 0);
        chk("rst_cnt", cr0, 0);
        @(negedge clk) rst_n = 1;
        step();
        chk("rst_in_ready", ir0, 1);

        for (int i = 0; i < 12; i++) send0(sp_d[i], sp_t[i], sp_sn[i], 1);
        sel0 = 0; #1 chk("sp_cnt_zero", cr0, 2);
        sel0 = 4; #1 chk("sp_cnt_nan", cr0, 4);
        chk("sp_sticky_all", st0, 5'b11111);
        for (int k = 5; k < 8; k++) begin
            sel0 = 3'(k);
            send0(32'h3F800000, 5'b00010, 0, 1);
            chk("sp_cnt_sel_hi", cr0, 0);
        end
        sel0 = 1;
        step();
        clr0 = 1; step(); clr0 = 0;
        chk("sp_clr_cnt", cr0, 0);
        chk("sp_clr_sticky", st0, 0);

        r0 = 0;
        send0(32'hBF800000, 5'b00010, 0, 0);
        e.t = 5'b01000; e.s = 0; e.sn = 0; e.due = -1;
        v0 = 1; d0 = 32'h7F800000;
        q0.push_back(e);
        for (int i = 0; i < 4; i++) begin
            chk("bp_in_ready", ir0, 0);
            chk("bp_out_valid", ov0, 1);
            chk("bp_out_type", ot0, 5'b00010);
            chk("bp_out_sign", os0, 1);
            sel0 = 1; #1 chk("bp_cnt_normal", cr0, 1);
            sel0 = 3; #1 chk("bp_cnt_inf_pending", cr0, 0);
            step();
        end
        r0 = 1;
        #1 chk("bp_release_in_ready", ir0, 1);
        step();
        v0 = 0;
        chk("bp_inf_out_type", ot0, 5'b01000);
        chk("bp_cnt_inf", cr0, 1);
        step();

        r0 = 0;
        send0(32'h40000000, 5'b00010, 0, 0);
        sel0 = 1;
        #3 rst_n = 0;
        #1;
        chk("arst_out_valid", ov0, 0);
        chk("arst_cnt", cr0, 0);
        chk("arst_sticky", st0, 0);
        chk("arst_out_type", ot0, 0);
        q0.delete();
        @(negedge clk) rst_n = 1;
        r0 = 1;
        step();
        send0(32'h00000001, 5'b00100, 0, 1);
        step();

        for (int i = 0; i < 6; i++) begin
            e.t = hp_t[i]; e.s = hp_s[i]; e.sn = hp_sn[i]; e.due = cyc + 1;
            v2 = 1; d2 = hp_d[i];
            q2.push_back(e);
            step();
        end
        v2 = 0;
        step();

        v1 = 1; d1 = 32'h3F800000;
        for (int i = 0; i < 20; i++) step();
        chk("sat_cnt", cr1, 15);
        chk("sat_sticky", st1, 5'b00010);
        clr1 = 1;
        step();
        v1 = 0; clr1 = 0;
        chk("sat_clr_cnt", cr1, 0);
        chk("sat_clr_sticky", st1, 0);
        chk("sat_clr_out_type", ot1, 5'b00010);
        chk("sat_clr_out_valid", ov1, 1);

        step(); step();
        chk("sp_queue_drained", q0.size(), 0);
        chk("hp_queue_drained", q2.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/float_classify_stream.md
Name: float_classify_stream

Overview:
- Streaming IEEE-754 operand classifier for arbitrary exponent and mantissa widths, with a valid/ready handshake on input and output.
- Registered output stage; per-class saturating event counters and sticky flags readable by the datapath/debug logic.
- Sits ahead of the FPU decode path; supersedes the single-precision combinational classifier.

Parameters:
- EXP_W, 8, exponent field width (>=2)
- MAN_W, 23, trailing-significand width (>=2)
- CNT_W, 16, width of each per-class event counter

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand valid
- in_ready  output  1  block can accept operand
- in_data  input  EXP_W+MAN_W+1  operand {sign, exponent, mantissa}
- out_valid  output  1  classification valid
- out_ready  input  1  consumer accepts classification
- out_type  output  5  one-hot class: [0] zero, [1] normal, [2] subnormal, [3] infinity, [4] NaN
- out_sign  output  1  sign bit of classified operand
- out_snan  output  1  1 when NaN with mantissa MSB = 0 (signalling)
- cnt_clr  input  1  synchronous clear of counters and sticky flags
- cnt_sel  input  3  counter select, same index as out_type bit
- cnt_rdata  output  CNT_W  selected counter value
- sticky  output  5  per-class "seen since clear" flags

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_type=0, out_sign=0, out_snan=0, all counters=0, sticky=0. Operand in flight is discarded. in_ready=1 as soon as reset deasserts.
- Classification (exp = exponent field, man = mantissa field):
  - exp all-0, man=0 -> zero
  - exp all-0, man!=0 -> subnormal
  - exp all-1, man=0 -> infinity
  - exp all-1, man!=0 -> NaN
  - otherwise normal
  - Exactly one out_type bit is set whenever out_valid=1.
- out_snan = NaN & ~man[MAN_W-1]; 0 for non-NaN.
- Handshake:
  - Accept occurs when in_valid & in_ready.
  - in_ready = ~out_valid | out_ready, so the block supports full throughput with no bubble.
  - Latency: result is registered and out_valid=1 on the cycle after accept.
  - out_* are held stable while out_valid & ~out_ready.
  - out_valid drops after an out_ready handshake unless a new accept happens in the same cycle; in that case the output register is reloaded.
- Counters:
  - On accept, the counter for the operand's class increments by 1, saturating at 2^CNT_W-1 (no wrap). The matching sticky bit is set.
  - Counting happens at accept, not at output handshake.
- cnt_clr:
  - Clears all counters and sticky flags on the next edge.
  - If an accept occurs in the same cycle, clear wins and that operand is not counted. Its classification still flows to the output.
  - cnt_clr does not affect the handshake or out_* registers.
- cnt_rdata: combinational from counter registers. cnt_sel 5..7 reads 0.
- in_data is ignored when in_valid=0. The NaN payload is not propagated.

Test Plan:
- Default params, back-to-back single-precision operands with out_ready=1: 0x00000000, 0x3F800000, 0x00000001, 0x7F800000, 0x7FC00000, 0x7F800001 -> out_type 00001, 00010, 00100, 01000, 10000, 10000 on consecutive cycles, each one cycle after accept. out_snan is 0 for 0x7FC00000 and 1 for 0x7F800001. Sign-flipped copies give out_sign=1 with identical out_type.
- Backpressure: accept 0xBF800000, hold out_ready=0 for 4 cycles with in_valid=1 and in_data=0x7F800000. Required: in_ready=0, outputs frozen at normal/sign=1, normal counter=1. Release out_ready -> the pending operand is accepted the same cycle and the infinity result appears next cycle.
- Saturation with CNT_W=4: 20 accepted 0x3F800000 -> cnt_sel=1 reads 15 and sticky=00010. Assert cnt_clr together with a 21st accept -> counter=0 and sticky=0 next cycle, while out_type still shows normal.
- Half precision (EXP_W=5, MAN_W=10): 0x7C00 -> infinity, 0x0400 -> normal, 0x03FF -> subnormal, 0x7E00 -> NaN with out_snan=0, 0x8000 -> zero with out_sign=1.
- Reset mid-operation: rst_n low asynchronously while out_valid=1 and counters are nonzero -> out_valid, counters and sticky read 0 immediately without a clock edge. First accept after release classifies correctly with latency 1.
- cnt_sel=5,6,7 -> cnt_rdata=0 regardless of traffic.
